// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the 74.25 MHz reference clock: pulses PLL rst, waits for stable lock, releases the core.
// Optional lock-loss counter is enabled by defining PLL_LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1048576,
    parameter int SETTLE_CYCLES = 4096,
    parameter int CNT_W         = 24
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic [1:0] seq_state,
    output logic [3:0] retry_cnt,
    output logic       timeout_err,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'b00,
        ST_WAIT_LOCK = 2'b01,
        ST_SETTLE    = 2'b10,
        ST_RUN       = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             locked_p0;
    logic             locked_p1;
    logic             locked_s;

    function automatic logic [3:0] sat_inc_retry(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // pll_locked is asynchronous to clk_74a: two-flop synchronizer
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            locked_p0 <= 1'b0;
            locked_p1 <= 1'b0;
        end else begin
            locked_p0 <= pll_locked;
            locked_p1 <= locked_p0;
        end
    end

    assign locked_s  = locked_p1;
    assign seq_state = state;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_PLL_RST;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            retry_cnt    <= 4'd0;
            timeout_err  <= 1'b0;
        end else if (restart_req) begin
            state        <= ST_PLL_RST;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state   <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    // lock takes precedence over a coincident timeout
                    if (locked_s) begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= ST_PLL_RST;
                        cnt         <= '0;
                        pll_rst     <= 1'b1;
                        retry_cnt   <= sat_inc_retry(retry_cnt);
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (!locked_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        state        <= ST_RUN;
                        cnt          <= '0;
                        core_reset_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    // lock loss re-waits for lock without re-pulsing the PLL
                    if (!locked_s) begin
                        state        <= ST_WAIT_LOCK;
                        cnt          <= '0;
                        core_reset_n <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_PLL_RST;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    function automatic logic [7:0] sat_inc_loss(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_cnt <= 8'd0;
        end else if (!restart_req && state == ST_RUN && !locked_s) begin
            lock_loss_cnt <= sat_inc_loss(lock_loss_cnt);
        end
    end
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer (RST_CYCLES=16, LOCK_TIMEOUT=256, SETTLE_CYCLES=64).
module tb_pll_reset_sequencer;

    localparam int SEL_PLL_RST = 0;
    localparam int SEL_CORE    = 1;
    localparam int SEL_STATE   = 2;
    localparam int SEL_RETRY   = 3;
    localparam int SEL_TOERR   = 4;
    localparam int SEL_LOSS    = 5;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    localparam int LOSS_ONE = 1;
`else
    localparam int LOSS_ONE = 0;
`endif

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       core_reset_n;
    logic [1:0] seq_state;
    logic [3:0] retry_cnt;
    logic       timeout_err;
    logic [7:0] lock_loss_cnt;

    pll_reset_sequencer #(
        .RST_CYCLES   (16),
        .LOCK_TIMEOUT (256),
        .SETTLE_CYCLES(64),
        .CNT_W        (24)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .restart_req  (restart_req),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .seq_state    (seq_state),
        .retry_cnt    (retry_cnt),
        .timeout_err  (timeout_err),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_74a = ~clk_74a;

    typedef struct {
        int    at;
        int    sel;
        int    exp;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   imm_pending = 1'b0;
    bit   stim_done = 1'b0;
    event chk_now;

    always @(posedge clk_74a) cyc <= cyc + 1;

    // at = -1 marks an immediate (clockless) check
    task automatic expect_at(input int at, input int sel, input int exp, input string name);
        exp_t e;
        int   idx;
        e.at = at; e.sel = sel; e.exp = exp; e.name = name;
        idx = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].at > at) begin
                idx = i;
                break;
            end
        end
        q.insert(idx, e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk_74a);
            #1;
        end
    endtask

    function automatic int dut_val(input int sel);
        case (sel)
            SEL_PLL_RST: return int'(pll_rst);
            SEL_CORE:    return int'(core_reset_n);
            SEL_STATE:   return int'(seq_state);
            SEL_RETRY:   return int'(retry_cnt);
            SEL_TOERR:   return int'(timeout_err);
            default:     return int'(lock_loss_cnt);
        endcase
    endfunction

    task automatic compare(input exp_t e, input bit missed);
        int act;
        act = dut_val(e.sel);
        checks++;
        if (missed) begin
            failures++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.at, cyc);
        end else if (act != e.exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", e.name, cyc, act, e.exp);
        end
    endtask

    // monitor: pops expectations when the DUT presents the matching cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_74a or chk_now);
            if (imm_pending) begin
                while (q.size() > 0 && q[0].at == -1) begin
                    e = q.pop_front();
                    compare(e, 1'b0);
                end
                imm_pending = 1'b0;
            end else begin
                while (q.size() > 0 && q[0].at >= 0 && q[0].at <= cyc) begin
                    e = q.pop_front();
                    compare(e, e.at < cyc);
                end
            end
        end
    end

    initial begin
        int k, p, t, s, r;
        reset_n = 1'b0;
        pll_locked = 1'b0;
        restart_req = 1'b0;

        // lock never arrives: periodic re-pulse, saturating retries
        wait_to(3);
        reset_n = 1'b1;
        k = cyc;
        expect_at(k, SEL_STATE, 0, "rst_state");
        expect_at(k, SEL_PLL_RST, 1, "rst_pll_rst");
        expect_at(k, SEL_CORE, 0, "rst_core");
        expect_at(k, SEL_RETRY, 0, "rst_retry");
        expect_at(k, SEL_TOERR, 0, "rst_toerr");
        expect_at(k, SEL_LOSS, 0, "rst_loss");
        expect_at(k + 15, SEL_PLL_RST, 1, "t2_pulse_end");
        expect_at(k + 16, SEL_PLL_RST, 0, "t2_pulse_off");
        expect_at(k + 16, SEL_STATE, 1, "t2_wait");
        expect_at(k + 271, SEL_TOERR, 0, "t2_toerr_pre");
        expect_at(k + 271, SEL_STATE, 1, "t2_wait_last");
        expect_at(k + 272, SEL_STATE, 0, "t2_repulse_state");
        expect_at(k + 272, SEL_PLL_RST, 1, "t2_repulse");
        expect_at(k + 272, SEL_TOERR, 1, "t2_toerr");
        expect_at(k + 272, SEL_RETRY, 1, "t2_retry1");
        expect_at(k + 288, SEL_PLL_RST, 0, "t2_pulse2_off");
        expect_at(k + 544, SEL_PLL_RST, 1, "t2_repulse2");
        expect_at(k + 544, SEL_RETRY, 2, "t2_retry2");
        expect_at(k + 4080, SEL_RETRY, 15, "t2_retry15");
        expect_at(k + 4624, SEL_RETRY, 15, "t2_retry_sat");
        expect_at(k + 4624, SEL_PLL_RST, 1, "t2_repulse17");
        expect_at(k + 4624, SEL_CORE, 0, "t2_core_low");
        expect_at(k + 4640, SEL_STATE, 1, "t6_wait");
        expect_at(k + 4641, SEL_STATE, 2, "t6_settle");

        // lock arrives mid-pulse, then reset asserted mid-SETTLE
        wait_to(k + 4630);
        pll_locked = 1'b1;
        wait_to(k + 4650);
        #1;
        reset_n = 1'b0;
        #1;
        expect_at(-1, SEL_STATE, 0, "t6_async_state");
        expect_at(-1, SEL_PLL_RST, 1, "t6_async_pll_rst");
        expect_at(-1, SEL_CORE, 0, "t6_async_core");
        expect_at(-1, SEL_RETRY, 0, "t6_async_retry");
        expect_at(-1, SEL_TOERR, 0, "t6_async_toerr");
        expect_at(-1, SEL_LOSS, 0, "t6_async_loss");
        imm_pending = 1'b1;
        ->chk_now;
        pll_locked = 1'b0;

        // normal bring-up, lock at c40
        wait_to(cyc + 3);
        reset_n = 1'b1;
        k = cyc;
        expect_at(k + 15, SEL_PLL_RST, 1, "t1_pulse_end");
        expect_at(k + 16, SEL_PLL_RST, 0, "t1_pulse_off");
        expect_at(k + 42, SEL_STATE, 1, "t1_wait_sync");
        expect_at(k + 43, SEL_STATE, 2, "t1_settle");
        expect_at(k + 106, SEL_CORE, 0, "t1_core_pre");
        expect_at(k + 107, SEL_CORE, 1, "t1_core_rel");
        expect_at(k + 107, SEL_STATE, 3, "t1_run");
        expect_at(k + 107, SEL_RETRY, 0, "t1_retry");
        wait_to(k + 40);
        pll_locked = 1'b1;

        // lock loss in RUN, then a 3-cycle glitch during SETTLE
        t = k + 120;
        s = t + 13;
        expect_at(t + 2, SEL_CORE, 1, "t4_core_hold");
        expect_at(t + 3, SEL_CORE, 0, "t4_core_drop");
        expect_at(t + 3, SEL_STATE, 1, "t4_wait");
        expect_at(t + 3, SEL_LOSS, LOSS_ONE, "t4_loss_cnt");
        expect_at(t + 3, SEL_PLL_RST, 0, "t4_no_repulse");
        expect_at(s, SEL_STATE, 2, "t4_settle");
        expect_at(s + 32, SEL_STATE, 2, "t3_settle_hold");
        expect_at(s + 33, SEL_STATE, 1, "t3_back_wait");
        expect_at(s + 35, SEL_STATE, 1, "t3_still_wait");
        expect_at(s + 36, SEL_STATE, 2, "t3_resettle");
        expect_at(s + 40, SEL_PLL_RST, 0, "t3_no_repulse");
        expect_at(s + 99, SEL_CORE, 0, "t3_full_settle");
        expect_at(s + 100, SEL_CORE, 1, "t3_core_rel");
        expect_at(s + 100, SEL_STATE, 3, "t3_run");
        expect_at(s + 100, SEL_RETRY, 0, "t3_retry");
        expect_at(s + 100, SEL_LOSS, LOSS_ONE, "t3_loss_same");
        wait_to(t);
        pll_locked = 1'b0;
        wait_to(t + 10);
        pll_locked = 1'b1;
        wait_to(s + 30);
        pll_locked = 1'b0;
        wait_to(s + 33);
        pll_locked = 1'b1;

        // software restart from RUN
        r = s + 110;
        expect_at(r, SEL_CORE, 1, "t5_core_pre");
        expect_at(r + 1, SEL_CORE, 0, "t5_core_drop");
        expect_at(r + 1, SEL_PLL_RST, 1, "t5_pll_rst");
        expect_at(r + 1, SEL_STATE, 0, "t5_state");
        expect_at(r + 16, SEL_PLL_RST, 1, "t5_pulse_end");
        expect_at(r + 17, SEL_PLL_RST, 0, "t5_pulse_off");
        expect_at(r + 17, SEL_STATE, 1, "t5_wait");
        expect_at(r + 18, SEL_STATE, 2, "t5_settle");
        expect_at(r + 81, SEL_CORE, 0, "t5_core_pre_rel");
        expect_at(r + 82, SEL_CORE, 1, "t5_core_rel");
        expect_at(r + 82, SEL_RETRY, 0, "t5_retry");
        expect_at(r + 82, SEL_LOSS, LOSS_ONE, "t5_loss_same");
        wait_to(r);
        restart_req = 1'b1;
        wait_to(r + 1);
        restart_req = 1'b0;
        wait_to(r + 90);
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done == 1'b1 || cyc > 20000);
        repeat (5) @(posedge clk_74a);
        if (!stim_done) begin
            failures++;
            $display("FAIL stim_timeout: stimulus reached cycle %0d, expected completion", cyc);
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.at, cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
